// File: rtl/cordic_atan2.sv
// Iterative vectoring-mode CORDIC returning float32 atan2(dataa = y, datab = x) in radians.
// Operands are aligned into a shared Q4.25 frame, rotated onto the x axis, then repacked.
module cordic_atan2 #(
    parameter int unsigned M  = 22,
    parameter int unsigned ZW = 28,
    parameter int unsigned XW = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    localparam logic signed [ZW-1:0] Pi = ZW'(105414357);

    typedef enum logic [2:0] {StIdle, StAlign, StIter, StFixup, StPack} state_e;

    state_e                 state_q;
    logic [31:0]            op_y_q, op_x_q;
    logic signed [XW-1:0]   x_q, y_q;
    logic signed [ZW-1:0]   z_q, theta_q;
    logic [4:0]             i_q;

    // round(atan(2^-i) * 2^25)
    function automatic logic signed [ZW-1:0] atan_tab(input logic [4:0] idx);
        case (idx)
            5'd0:    return ZW'(26353589);
            5'd1:    return ZW'(15557432);
            5'd2:    return ZW'(8220120);
            5'd3:    return ZW'(4172661);
            5'd4:    return ZW'(2094428);
            5'd5:    return ZW'(1048235);
            5'd6:    return ZW'(524245);
            5'd7:    return ZW'(262139);
            5'd8:    return ZW'(131071);
            5'd9:    return ZW'(65536);
            5'd10:   return ZW'(32768);
            5'd11:   return ZW'(16384);
            5'd12:   return ZW'(8192);
            5'd13:   return ZW'(4096);
            5'd14:   return ZW'(2048);
            5'd15:   return ZW'(1024);
            5'd16:   return ZW'(512);
            5'd17:   return ZW'(256);
            5'd18:   return ZW'(128);
            5'd19:   return ZW'(64);
            5'd20:   return ZW'(32);
            5'd21:   return ZW'(16);
            5'd22:   return ZW'(8);
            5'd23:   return ZW'(4);
            default: return '0;
        endcase
    endfunction

    // Alignment of latched operands
    logic [7:0]           exp_y, exp_x, exp_max, sh_y, sh_x;
    logic [XW-1:0]        y_align, x_align;
    logic                 y_zero, x_zero, sx, sy;

    always_comb begin
        exp_y   = op_y_q[30:23];
        exp_x   = op_x_q[30:23];
        sy      = op_y_q[31];
        sx      = op_x_q[31];
        y_zero  = (exp_y == 8'd0);
        x_zero  = (exp_x == 8'd0);
        exp_max = (exp_y > exp_x) ? exp_y : exp_x;
        sh_y    = exp_max - exp_y;
        sh_x    = exp_max - exp_x;
        y_align = (y_zero || sh_y >= 8'd25) ? '0 : (XW'({1'b1, op_y_q[22:0], 2'b00}) >> sh_y);
        x_align = (x_zero || sh_x >= 8'd25) ? '0 : (XW'({1'b1, op_x_q[22:0], 2'b00}) >> sh_x);
    end

    // One CORDIC micro-rotation
    logic signed [XW-1:0] x_sh, y_sh, x_d, y_d;
    logic signed [ZW-1:0] e_i, z_d;

    always_comb begin
        x_sh = x_q >>> i_q;
        y_sh = y_q >>> i_q;
        e_i  = atan_tab(i_q);
        if (!y_q[XW-1]) begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + e_i;
        end else begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - e_i;
        end
    end

    // Quadrant fix-up from the first-quadrant angle
    logic signed [ZW-1:0] a_mag, theta_abs, theta_d;

    always_comb begin
        a_mag     = z_q[ZW-1] ? '0 : z_q;
        theta_abs = sx ? (Pi - a_mag) : a_mag;
        if (y_zero && x_zero) begin
            theta_d = '0;
        end else if (y_zero && sx) begin
            theta_d = Pi;
        end else begin
            theta_d = sy ? -theta_abs : theta_abs;
        end
    end

    // Fixed-point to float32, mantissa truncated
    logic [ZW-1:0] mag;
    logic [7:0]    lead;
    logic [22:0]   mant;
    logic [31:0]   packed_f;

    always_comb begin
        mag  = theta_q[ZW-1] ? ZW'(-theta_q) : ZW'(theta_q);
        lead = 8'd0;
        for (int k = 0; k < ZW; k++) begin
            if (mag[k]) lead = 8'(k);
        end
        mant     = 23'({mag, 23'b0} >> lead);
        packed_f = (mag == '0) ? 32'h0000_0000 : {theta_q[ZW-1], 8'd102 + lead, mant};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            i_q     <= '0;
            op_y_q  <= '0;
            op_x_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            theta_q <= '0;
        end else if (clk_en) begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        op_y_q  <= dataa;
                        op_x_q  <= datab;
                        busy    <= 1'b1;
                        state_q <= StAlign;
                    end
                end
                StAlign: begin
                    x_q     <= x_align;
                    y_q     <= y_align;
                    z_q     <= '0;
                    i_q     <= '0;
                    state_q <= StIter;
                end
                StIter: begin
                    x_q <= x_d;
                    y_q <= y_d;
                    z_q <= z_d;
                    if (i_q == 5'(M - 1)) begin
                        i_q     <= '0;
                        state_q <= StFixup;
                    end else begin
                        i_q <= i_q + 5'd1;
                    end
                end
                StFixup: begin
                    theta_q <= theta_d;
                    state_q <= StPack;
                end
                StPack: begin
                    result  <= packed_f;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_atan2.sv
// Bench for cordic_atan2: vector table, timing corner sequences and random operands
// checked through a scoreboard against a real-valued atan2 model.
module tb_cordic_atan2;
    localparam int  M   = 22;
    localparam real TOL = 4.0e-6;

    logic        clk = 1'b0;
    logic        rst, clk_en, start;
    logic [31:0] dataa, datab;
    logic        busy, done;
    logic [31:0] result;

    always #5 clk = ~clk;

    cordic_atan2 #(.M(M), .ZW(28), .XW(30)) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .start  (start),
        .dataa  (dataa),
        .datab  (datab),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    typedef struct {
        logic [31:0] y;
        logic [31:0] x;
        logic [31:0] exp_bits;
        bit          exact;
        string       name;
    } vec_t;

    typedef struct {
        real         ref_v;
        logic [31:0] exp_bits;
        bit          exact;
        string       name;
    } exp_t;

    vec_t vq[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic real f2r(input logic [31:0] f);
        int  e;
        real v;
        e = int'(f[30:23]);
        if (e == 0) return 0.0;
        v = (1.0 + $itor(f[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return f[31] ? -v : v;
    endfunction

    task automatic check(input string name, input bit ok, input string got, input string want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %s, expected %s", name, got, want);
        end
    endtask

    task automatic add_vec(input logic [31:0] y, input logic [31:0] x, input logic [31:0] eb,
                           input bit exact, input string name);
        vec_t v;
        v.y = y; v.x = x; v.exp_bits = eb; v.exact = exact; v.name = name;
        vq.push_back(v);
    endtask

    // Scoreboard consumer: one pop per rising done pulse
    logic done_prev = 1'b0;
    exp_t m_e;
    real  m_got;
    bit   m_ok;
    always @(negedge clk) begin
        if (done && !done_prev) begin
            check("done_expected", sb.size() != 0, $sformatf("done with %h", result),
                  "no done pulse");
            if (sb.size() != 0) begin
                m_e   = sb.pop_front();
                m_got = f2r(result);
                if (m_e.exact) begin
                    check(m_e.name, result == m_e.exp_bits, $sformatf("%h", result),
                          $sformatf("%h", m_e.exp_bits));
                end else begin
                    m_ok = (m_got - m_e.ref_v <= TOL) && (m_e.ref_v - m_got <= TOL);
                    if (m_e.ref_v > 1.0e-5 || m_e.ref_v < -1.0e-5)
                        m_ok = m_ok && (result[31] == (m_e.ref_v < 0.0));
                    check(m_e.name, m_ok, $sformatf("%h (%.9f)", result, m_got),
                          $sformatf("%.9f +- %g", m_e.ref_v, TOL));
                end
            end
        end
        done_prev = done;
    end

    task automatic issue(input logic [31:0] y, input logic [31:0] x, input real ref_v,
                         input bit exact, input logic [31:0] eb, input string name);
        exp_t e;
        @(negedge clk);
        dataa = y;
        datab = x;
        start = 1'b1;
        e.ref_v = ref_v; e.exp_bits = eb; e.exact = exact; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Called #1 after the accepting edge (cycle 1); returns the cycle where done is seen.
    task automatic wait_done(input int stall_at, input int stall_len, input int poke_at,
                             output int cycles, output bit busy_ok);
        cycles  = 1;
        busy_ok = busy;
        while (!done && cycles < 200) begin
            start = (cycles == poke_at);
            if (start) begin
                dataa = 32'hBF80_0000;
                datab = 32'hBF80_0000;
            end
            if (cycles == stall_at) clk_en = 1'b0;
            if (cycles == stall_at + stall_len) clk_en = 1'b1;
            @(posedge clk);
            #1;
            cycles++;
            if (!done && !busy) busy_ok = 1'b0;
        end
        start  = 1'b0;
        clk_en = 1'b1;
        check("done_timeout", done, $sformatf("no done after %0d cycles", cycles), "done");
    endtask

    int          cyc, ndone;
    bit          bok;
    logic [31:0] ry, rx;

    initial begin
        rst = 1'b0; clk_en = 1'b1; start = 1'b0; dataa = '0; datab = '0;

        add_vec(32'h3F80_0000, 32'h3F80_0000, 32'h3F49_0FDB, 1'b0, "q1_pi_4");
        add_vec(32'h3F80_0000, 32'hBF80_0000, 32'h4016_CBE4, 1'b0, "q2_3pi_4");
        add_vec(32'hBF00_0000, 32'h0000_0000, 32'hBFC9_0FDB, 1'b0, "neg_pi_2");
        add_vec(32'h0000_0000, 32'hC000_0000, 32'h4049_0FDB, 1'b0, "y0_xneg_pi");
        add_vec(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, "both_zero");
        add_vec(32'h3F80_0000, 32'h4F80_0000, 32'h2F80_0000, 1'b0, "exp_gap");
        add_vec(32'hBF80_0000, 32'hBF80_0000, 32'hC016_CBE4, 1'b0, "q3_m3pi_4");
        add_vec(32'hBF80_0000, 32'h3F80_0000, 32'hBF49_0FDB, 1'b0, "q4_mpi_4");
        add_vec(32'h8000_0000, 32'hC000_0000, 32'h4049_0FDB, 1'b0, "ynegzero_pi");
        add_vec(32'h3F80_0000, 32'h8000_0000, 32'h3FC9_0FDB, 1'b0, "xnegzero_pi_2");
        add_vec(32'h0040_0000, 32'hBF80_0000, 32'h4049_0FDB, 1'b0, "denorm_y_pi");
        add_vec(32'h4B00_0000, 32'h4B00_0000, 32'h3F49_0FDB, 1'b0, "large_pi_4");
        add_vec(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, "both_negzero");
        add_vec(32'h3F80_0000, 32'h0000_0000, 32'h3FC9_0FDB, 1'b0, "pi_2");

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   busy == 1'b0, $sformatf("%b", busy), "0");
        check("reset_done",   done == 1'b0, $sformatf("%b", done), "0");
        check("reset_result", result == 32'h0, $sformatf("%h", result), "00000000");
        rst = 1'b1;

        // Latency and busy window
        issue(32'h3F80_0000, 32'h3F80_0000, f2r(32'h3F49_0FDB), 1'b0, '0, "lat_pi_4");
        wait_done(-1, 0, -1, cyc, bok);
        check("latency", cyc == M + 4, $sformatf("%0d", cyc), $sformatf("%0d", M + 4));
        check("busy_window", bok && !busy, $sformatf("ok=%b busy=%b", bok, busy), "ok=1 busy=0");

        // Done holds while clk_en is low, clears on the next enabled edge
        clk_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("done_hold", done == 1'b1, $sformatf("%b", done), "1");
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        check("done_clear", done == 1'b0, $sformatf("%b", done), "0");

        // Vector table, issued back-to-back in each done cycle
        foreach (vq[k]) begin
            issue(vq[k].y, vq[k].x, f2r(vq[k].exp_bits), vq[k].exact, vq[k].exp_bits, vq[k].name);
            wait_done(-1, 0, -1, cyc, bok);
            check({vq[k].name, "_latency"}, cyc == M + 4, $sformatf("%0d", cyc),
                  $sformatf("%0d", M + 4));
        end

        // Stall mid-ITER for 5 cycles plus an ignored start while busy
        issue(32'h3F80_0000, 32'h3F80_0000, f2r(32'h3F49_0FDB), 1'b0, '0, "stall_pi_4");
        wait_done(8, 5, 3, cyc, bok);
        check("stall_latency", cyc == M + 9, $sformatf("%0d", cyc), $sformatf("%0d", M + 9));
        repeat (40) @(posedge clk);

        // Reset mid-operation aborts without a done pulse
        issue(32'h3F80_0000, 32'h3F80_0000, 0.0, 1'b0, '0, "aborted");
        repeat (9) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        check("abort_busy",   busy == 1'b0, $sformatf("%b", busy), "0");
        check("abort_done",   done == 1'b0, $sformatf("%b", done), "0");
        check("abort_result", result == 32'h0, $sformatf("%h", result), "00000000");
        if (sb.size() > 0) sb.delete(sb.size() - 1);
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("abort_no_done", ndone == 0, $sformatf("%0d", ndone), "0");
        issue(32'h3F80_0000, 32'h3F80_0000, f2r(32'h3F49_0FDB), 1'b0, '0, "post_abort");
        wait_done(-1, 0, -1, cyc, bok);
        check("post_abort_latency", cyc == M + 4, $sformatf("%0d", cyc), $sformatf("%0d", M + 4));

        // Random finite operands with moderate exponent spread
        for (int n = 0; n < 1000; n++) begin
            ry = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
            rx = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
            issue(ry, rx, $atan2(f2r(ry), f2r(rx)), 1'b0, '0,
                  $sformatf("rand y=%h x=%h", ry, rx));
            wait_done(-1, 0, -1, cyc, bok);
        end

        repeat (5) @(posedge clk);
        check("scoreboard_drained", sb.size() == 0, $sformatf("%0d left", sb.size()), "0 left");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
